// File: rtl/crossbar_pkg.sv
// Shared types and constants for the crossbar control sequencer.
package crossbar_pkg;

    localparam int CTRL_W  = 5;
    localparam int N_PORTS = 4;
    localparam int DWELL_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One schedule slot: crossbar routing word plus extra hold cycles.
    typedef struct packed {
        logic [CTRL_W-1:0]  ctrl;
        logic [DWELL_W-1:0] dwell;
    } sched_entry_t;

endpackage

// File: rtl/crossbar_sched_table.sv
// Schedule register file: async clear, one sync write port, one comb read port.
// A same-cycle read of the entry being written returns the old contents.
module crossbar_sched_table #(
    parameter  int DEPTH   = 8,
    parameter  int CTRL_W  = 5,
    parameter  int DWELL_W = 4,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [CTRL_W-1:0]  wr_ctrl,
    input  logic [DWELL_W-1:0] wr_dwell,
    input  logic [AW-1:0]      rd_addr,
    output logic [CTRL_W-1:0]  rd_ctrl,
    output logic [DWELL_W-1:0] rd_dwell
);
    import crossbar_pkg::*;

    logic [DEPTH-1:0][CTRL_W-1:0]  ctrl_q;
    logic [DEPTH-1:0][DWELL_W-1:0] dwell_q;

    // Table storage: cleared on reset, written one entry per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            dwell_q <= '0;
        end else if (wr_en) begin
            ctrl_q[wr_addr]  <= wr_ctrl;
            dwell_q[wr_addr] <= wr_dwell;
        end
    end

    assign rd_ctrl  = ctrl_q[rd_addr];
    assign rd_dwell = dwell_q[rd_addr];

endmodule

// File: rtl/crossbar_ctrl_sequencer.sv
// Steps the crossbar control word through a programmable schedule, once or looping.
module crossbar_ctrl_sequencer #(
    parameter  int CTRL_W  = 5,
    parameter  int DEPTH   = 8,
    parameter  int DWELL_W = 4,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [CTRL_W-1:0]  wr_ctrl,
    input  logic [DWELL_W-1:0] wr_dwell,
    input  logic [AW:0]        len,
    input  logic               loop,
    input  logic               start,
    input  logic               stop,
    output logic [CTRL_W-1:0]  control,
    output logic [AW-1:0]      entry_idx,
    output logic               busy,
    output logic               done
);
    import crossbar_pkg::*;

    state_t             state, state_nxt;
    logic [DWELL_W-1:0] cnt;
    logic [AW:0]        len_eff;
    logic [AW:0]        len_clip;
    logic               looped;
    logic               last;
    logic               load;
    logic               finish;
    logic [AW-1:0]      rd_addr;
    logic [CTRL_W-1:0]  rd_ctrl;
    logic [DWELL_W-1:0] rd_dwell;

    crossbar_sched_table #(
        .DEPTH  (DEPTH),
        .CTRL_W (CTRL_W),
        .DWELL_W(DWELL_W)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_ctrl (wr_ctrl),
        .wr_dwell(wr_dwell),
        .rd_addr (rd_addr),
        .rd_ctrl (rd_ctrl),
        .rd_dwell(rd_dwell)
    );

    // Requests longer than the table run the whole table.
    assign len_clip = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
    assign last     = ({1'b0, entry_idx} == (len_eff - 1'b1));
    // Read port always points at the entry that would be loaded next.
    assign rd_addr  = (state == RUN && !last) ? entry_idx + 1'b1 : '0;

    // Next-state and load/finish decisions; stop beats any advance.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !stop && len != '0) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    if (last && !looped) begin
                        state_nxt = IDLE;
                        finish    = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Output registers, dwell counter and run parameters latched at start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            control   <= '0;
            entry_idx <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            len_eff   <= '0;
            looped    <= 1'b0;
        end else begin
            busy <= (state_nxt == RUN);
            done <= finish;
            if (state == IDLE && state_nxt == RUN) begin
                len_eff <= len_clip;
                looped  <= loop;
            end
            if (load) begin
                control   <= rd_ctrl;
                entry_idx <= rd_addr;
                cnt       <= rd_dwell;
            end else if (state == RUN && !stop && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_crossbar_ctrl_sequencer.sv
// Directed bench for crossbar_ctrl_sequencer with a cycle-level behavioural model.
module tb_crossbar_ctrl_sequencer;
    import crossbar_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [4:0] wr_ctrl = '0;
    logic [3:0] wr_dwell = '0;
    logic [3:0] len = '0;
    logic       loop = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [4:0] control;
    logic [2:0] entry_idx;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    crossbar_ctrl_sequencer dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_ctrl(wr_ctrl), .wr_dwell(wr_dwell), .len(len), .loop(loop),
        .start(start), .stop(stop), .control(control), .entry_idx(entry_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: tracks the schedule as "entry i, cycles left".
    sched_entry_t m_tab [8];
    logic [4:0]   m_ctrl;
    int           m_idx, m_left, m_len;
    logic         m_loop, m_busy, m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_tab[i] <= '0;
            m_ctrl <= '0; m_idx <= 0; m_left <= 0; m_len <= 0;
            m_loop <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
        end else begin
            if (wr_en) m_tab[wr_addr] <= {wr_ctrl, wr_dwell};
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start && !stop && len != 0) begin
                    m_len  <= (int'(len) > 8) ? 8 : int'(len);
                    m_loop <= loop;
                    m_busy <= 1'b1;
                    m_idx  <= 0;
                    m_ctrl <= m_tab[0].ctrl;
                    m_left <= int'(m_tab[0].dwell) + 1;
                end
            end else if (stop) begin
                m_busy <= 1'b0;
            end else if (m_left > 1) begin
                m_left <= m_left - 1;
            end else if (m_idx + 1 < m_len) begin
                m_idx  <= m_idx + 1;
                m_ctrl <= m_tab[m_idx + 1].ctrl;
                m_left <= int'(m_tab[m_idx + 1].dwell) + 1;
            end else if (m_loop) begin
                m_idx  <= 0;
                m_ctrl <= m_tab[0].ctrl;
                m_left <= int'(m_tab[0].dwell) + 1;
            end else begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_control", int'(control), int'(m_ctrl));
        check("model_entry_idx", int'(entry_idx), m_idx);
        check("model_busy", int'(busy), int'(m_busy));
        check("model_done", int'(done), int'(m_done));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int a, input int c, input int d);
        wr_en = 1'b1; wr_addr = 3'(a); wr_ctrl = 5'(c); wr_dwell = 4'(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(input int l, input logic lp);
        len = 4'(l); loop = lp; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    int exp_one_c [8] = '{8'h03, 8'h11, 8'h11, 8'h11, 8'h1F, 8'h1F, 8'h1F, 8'h1F};
    int exp_one_b [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    int exp_one_d [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    int exp_loop  [6] = '{8'h03, 8'h11, 8'h11, 8'h11, 8'h1F, 8'h1F};

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int held, nbusy, ndone;
        step(3);
        rst_n = 1'b1;
        check("reset_control", int'(control), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_idx", int'(entry_idx), 0);

        // One-shot schedule
        wr(0, 5'h03, 0); wr(1, 5'h11, 2); wr(2, 5'h1F, 1);
        pulse_start(3, 1'b0);
        for (int k = 0; k < 8; k++) begin
            check("oneshot_control", int'(control), exp_one_c[k]);
            check("oneshot_busy", int'(busy), exp_one_b[k]);
            check("oneshot_done", int'(done), exp_one_d[k]);
            step(1);
        end

        // Loop schedule, then stop freezes control
        pulse_start(3, 1'b1);
        for (int k = 0; k < 12; k++) begin
            check("loop_control", int'(control), exp_loop[k % 6]);
            check("loop_done", int'(done), 0);
            step(1);
        end
        held = int'(control);
        stop = 1'b1; step(1); stop = 1'b0;
        check("stop_busy", int'(busy), 0);
        check("stop_frozen", int'(control), held);
        step(2);
        check("stop_still_frozen", int'(control), 8'h03);
        check("stop_no_done", int'(done), 0);

        // len == 0 is ignored
        pulse_start(0, 1'b0);
        check("len0_busy", int'(busy), 0);
        step(1);
        check("len0_done", int'(done), 0);

        // start together with stop is ignored
        stop = 1'b1; pulse_start(3, 1'b0); stop = 1'b0;
        check("startstop_busy", int'(busy), 0);

        // len beyond DEPTH runs all 8 entries
        for (int i = 0; i < 8; i++) wr(i, i + 8, 0);
        pulse_start(15, 1'b0);
        for (int k = 0; k < 8; k++) begin
            check("len15_idx", int'(entry_idx), k);
            check("len15_control", int'(control), k + 8);
            step(1);
        end
        check("len15_done", int'(done), 1);
        check("len15_last_idx", int'(entry_idx), 7);
        step(1);

        // Max dwell holds one entry for 16 cycles
        wr(0, 5'h05, 15);
        pulse_start(1, 1'b0);
        nbusy = 0; ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy) nbusy++;
            if (done) ndone++;
            step(1);
        end
        check("dwellF_cycles", nbusy, 16);
        check("dwellF_done_pulses", ndone, 1);

        // Rewrite entry 2 while entry 1 is active
        wr(0, 5'h03, 0); wr(1, 5'h11, 2); wr(2, 5'h1F, 1);
        pulse_start(3, 1'b0);
        step(1);
        wr(2, 5'h0A, 1);
        step(2);
        check("midrun_write", int'(control), 8'h0A);
        step(4);

        // Write entry 0 on the edge it is reloaded: old value first, new value next wrap
        pulse_start(3, 1'b1);
        step(5);
        wr(0, 5'h05, 0);
        check("same_edge_old", int'(control), 8'h03);
        step(6);
        check("same_edge_new", int'(control), 8'h05);

        // Asynchronous reset mid-run clears outputs and table
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_control", int'(control), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_idx", int'(entry_idx), 0);
        check("async_rst_done", int'(done), 0);
        step(2);
        rst_n = 1'b1;
        step(1);
        pulse_start(1, 1'b0);
        check("post_rst_control", int'(control), 0);
        check("post_rst_busy", int'(busy), 1);
        step(1);
        check("post_rst_done", int'(done), 1);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
